// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data-memory access controller.
//   DATA_W / ADDR_W : data and byte-address widths
//   state_t         : controller state encoding (IDLE/REQ/WAIT/DONE)
//   op_t            : latched access type
package dmem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_watchdog.sv
// Access watchdog: counts cycles while run is high and flags the cycle in
// which the count reaches TIMEOUT_CYCLES. Cleared whenever run is low.
//   clk, rst   : clock, async active-high reset
//   run        : controller is in REQ or WAIT
//   expired_c  : combinational, high in the TIMEOUT_CYCLES-th run cycle
module dmem_watchdog
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign expired_c = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // cnt holds the number of run cycles already elapsed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (run && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller. Accepts aligned load/store
// requests from XM, runs a req/done handshake with a multi-cycle memory and
// returns readData/stall to MW.
// Optional feature macro: DMEM_TIMEOUT_EN (watchdog, mem_err pulse).
//   clk, rst                 : clock, async active-high reset
//   XM_memRead/XM_memWrite   : load / store in M stage (both => store)
//   XM_aluOut, XM_writeData  : byte address, store data
//   XM_flush                 : M-stage instruction squashed (IDLE only)
//   mem_rd/mem_wr            : registered memory requests
//   mem_addr/mem_wr_data     : latched address / store data
//   mem_stall, mem_done      : memory refuses request / access complete
//   mem_rd_data              : read data, valid with mem_done
//   readData                 : last completed load result
//   stall, align_err_m       : combinational pipeline freeze / misalign flag
//   mem_err                  : watchdog timeout pulse
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              XM_memRead,
  input  logic              XM_memWrite,
  input  logic [ADDR_W-1:0] XM_aluOut,
  input  logic [DATA_W-1:0] XM_writeData,
  input  logic              XM_flush,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] readData,
  output logic              stall,
  output logic              align_err_m,
  output logic              mem_err
);

  state_t state, state_nxt;
  op_t    op, op_nxt;
  logic   req_c, accept_c, busy_c, complete_c, timeout_c;

  assign req_c      = (XM_memRead | XM_memWrite) & ~XM_flush;
  assign accept_c   = (state == S_IDLE) & req_c & ~XM_aluOut[0];
  assign busy_c     = (state == S_REQ) | (state == S_WAIT);
  // mem_done only counts in REQ once the memory has taken the request
  assign complete_c = ((state == S_REQ) & ~mem_stall & mem_done) |
                      ((state == S_WAIT) & mem_done);

  // Gated by rst so every output reads zero while reset is held
  assign stall       = ~rst & (accept_c | busy_c);
  assign align_err_m = ~rst & (state == S_IDLE) & req_c & XM_aluOut[0];

`ifdef DMEM_TIMEOUT_EN
  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .run      (busy_c),
    .expired_c(timeout_c)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_c      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state; completion wins over a simultaneous timeout
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    if (accept_c) op_nxt = XM_memWrite ? OP_WRITE : OP_READ;
    case (state)
      S_IDLE: if (accept_c) state_nxt = S_REQ;
      S_REQ: begin
        if (complete_c || timeout_c) state_nxt = S_DONE;
        else if (!mem_stall)         state_nxt = S_WAIT;
      end
      S_WAIT: if (complete_c || timeout_c) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request/data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= OP_READ;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      readData    <= '0;
      mem_err     <= 1'b0;
    end else begin
      op      <= op_nxt;
      mem_rd  <= (state_nxt == S_REQ) && (op_nxt == OP_READ);
      mem_wr  <= (state_nxt == S_REQ) && (op_nxt == OP_WRITE);
      mem_err <= timeout_c && !complete_c;
      if (accept_c) begin
        mem_addr    <= XM_aluOut;
        mem_wr_data <= XM_writeData;
      end
      if (busy_c && (op == OP_READ)) begin
        if (complete_c)     readData <= mem_rd_data;
        else if (timeout_c) readData <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        XM_memRead, XM_memWrite, XM_flush;
  logic [15:0] XM_aluOut, XM_writeData;
  logic        mem_rd, mem_wr, mem_stall, mem_done;
  logic [15:0] mem_addr, mem_wr_data, mem_rd_data, readData;
  logic        stall, align_err_m, mem_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_rdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .XM_memRead(XM_memRead), .XM_memWrite(XM_memWrite),
    .XM_aluOut(XM_aluOut), .XM_writeData(XM_writeData), .XM_flush(XM_flush),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rd_data(mem_rd_data),
    .readData(readData), .stall(stall), .align_err_m(align_err_m), .mem_err(mem_err)
  );

  typedef struct {
    logic        rd, wr, flush, flush_mid;
    logic [15:0] addr, wdata, rdata;
    int          nms, nw;
    int          exp_stall, exp_rd, exp_wr, exp_align;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          stall, rd, wr, align, err, addr_bad, wdata_bad, last_stall;
    logic [15:0] rdata;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic flush, input logic flush_mid,
                              input int nms, input int nw, input logic [15:0] rdata,
                              input int es, input int er, input int ew, input int ea,
                              input logic [15:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.flush = flush;
    v.flush_mid = flush_mid; v.nms = nms; v.nw = nw; v.rdata = rdata;
    v.exp_stall = es; v.exp_rd = er; v.exp_wr = ew; v.exp_align = ea; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic idle_inputs();
    XM_memRead = 0; XM_memWrite = 0; XM_flush = 0; XM_aluOut = '0; XM_writeData = '0;
    mem_stall = 0; mem_done = 0; mem_rd_data = '0;
  endtask

  // Present one M-stage instruction and act as memory with nms refusal
  // cycles and nw wait cycles; collect what the controller does.
  task automatic do_access(input vec_t v, output obs_t o);
    bit accepted;
    int total;
    o = '{default: 0};
    accepted = (v.rd || v.wr) && !v.addr[0] && !v.flush;
    total = accepted ? v.nms + v.nw + 3 : 2;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (accepted || k == 0) begin
        XM_memRead = v.rd; XM_memWrite = v.wr; XM_aluOut = v.addr; XM_writeData = v.wdata;
        XM_flush = (k == 0) ? v.flush : (v.flush_mid && k < total - 1);
      end else begin
        idle_inputs();
      end
      mem_stall   = accepted && k >= 1 && k <= v.nms;
      mem_done    = accepted && k == v.nms + 1 + v.nw;
      mem_rd_data = mem_done ? v.rdata : 16'($urandom);
      #1;
      if (stall)       o.stall++;
      if (mem_rd)      o.rd++;
      if (mem_wr)      o.wr++;
      if (align_err_m) o.align++;
      if (mem_err)     o.err++;
      if ((mem_rd || mem_wr) && mem_addr !== v.addr) o.addr_bad++;
      if (mem_wr && mem_wr_data !== v.wdata)         o.wdata_bad++;
      if (k == total - 1) begin
        o.rdata = readData;
        o.last_stall = int'(stall);
      end
    end
  endtask

  task automatic check_access(input string tag, input vec_t v, input obs_t o);
    chk({tag, "_stall_cycles"}, o.stall, v.exp_stall);
    chk({tag, "_rd_cycles"}, o.rd, v.exp_rd);
    chk({tag, "_wr_cycles"}, o.wr, v.exp_wr);
    chk({tag, "_align"}, o.align, v.exp_align);
    chk({tag, "_addr_bad"}, o.addr_bad, 0);
    chk({tag, "_wdata_bad"}, o.wdata_bad, 0);
    chk({tag, "_mem_err"}, o.err, 0);
    chk({tag, "_final_stall"}, o.last_stall, 0);
    chk({tag, "_readData"}, o.rdata, v.exp_rdata);
  endtask

  vec_t tbl[9];
  vec_t v;
  obs_t o;
  int   n;
  bit   seen;

  initial begin
    tbl[0] = mk(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 16'hBEEF, 2, 1, 0, 0, 16'hBEEF);
    tbl[1] = mk(0, 1, 16'h0020, 16'h1234, 0, 0, 3, 2, 16'h7777, 7, 0, 4, 0, 16'hBEEF);
    tbl[2] = mk(1, 0, 16'h0011, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'hBEEF);
    tbl[3] = mk(1, 0, 16'h0030, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hBEEF);
    tbl[4] = mk(1, 0, 16'h0040, 16'h0000, 0, 1, 0, 2, 16'hCAFE, 4, 1, 0, 0, 16'hCAFE);
    tbl[5] = mk(1, 1, 16'h0050, 16'h5A5A, 0, 0, 1, 0, 16'h1111, 3, 0, 2, 0, 16'hCAFE);
    tbl[6] = mk(1, 0, 16'h0060, 16'h0000, 0, 0, 2, 1, 16'h1357, 5, 3, 0, 0, 16'h1357);
    tbl[7] = mk(0, 0, 16'h0001, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h1357);
    tbl[8] = mk(0, 1, 16'h0023, 16'h4444, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h1357);

    // Reset state
    rst = 1; idle_inputs();
    repeat (2) @(negedge clk);
    XM_memRead = 1; XM_aluOut = 16'h0010;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_readData", readData, 0);
    chk("rst_align", align_err_m, 0);
    chk("rst_mem_err", mem_err, 0);
    @(negedge clk); idle_inputs(); rst = 0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_access(tbl[i], o);
      check_access($sformatf("vec%0d", i), tbl[i], o);
    end

    // Reset in WAIT abandons the access
    @(negedge clk); idle_inputs();
    XM_memRead = 1; XM_aluOut = 16'h0070;
    @(negedge clk);
    @(negedge clk); #1;
    chk("wait_stall_before_rst", stall, 1);
    rst = 1; #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_readData", readData, 0);
    chk("midrst_align", align_err_m, 0);
    @(negedge clk); idle_inputs(); rst = 0; #1;
    chk("postrst_stall", stall, 0);
    v = mk(1, 0, 16'h0002, 16'h0000, 0, 0, 0, 0, 16'h2468, 2, 1, 0, 0, 16'h2468);
    do_access(v, o);
    check_access("postrst", v, o);
    model_rdata = 16'h2468;

`ifdef DMEM_TIMEOUT_EN
    // Memory never answers: 8 busy cycles, then mem_err in DONE
    @(negedge clk); idle_inputs();
    XM_memRead = 1; XM_aluOut = 16'h0080;
    #1; chk("to_accept_stall", stall, 1);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); #1; n++;
      if (mem_err) seen = 1;
    end
    chk("to_latency", n, 9);
    chk("to_readData", readData, 0);
    chk("to_err_stall", stall, 0);
    @(negedge clk); idle_inputs(); mem_done = 1; mem_rd_data = 16'hFFFF; #1;
    chk("to_err_pulse", mem_err, 0);
    chk("to_late_done_stall", stall, 0);
    @(negedge clk); idle_inputs();
    XM_memRead = 1; XM_aluOut = 16'h0082; #1;
    chk("to_idle_accept", stall, 1);
    chk("to_late_done_ignored", readData, 0);
    @(negedge clk); mem_done = 1; mem_rd_data = 16'h0F0F;
    @(negedge clk); mem_done = 0; mem_rd_data = 16'h0000; #1;
    chk("to_recover_readData", readData, 16'h0F0F);
    model_rdata = 16'h0F0F;
`endif

    // Randomized accesses against the transaction-level model
    for (int i = 0; i < 60; i++) begin
      bit acc, isw;
      int sel;
      sel = $urandom_range(0, 7);
      v.rd = (sel <= 3) || (sel == 6);
      v.wr = (sel >= 4) && (sel <= 6);
      v.addr = 16'($urandom);
      v.addr[0] = ($urandom_range(0, 4) == 0);
      v.wdata = 16'($urandom);
      v.rdata = 16'($urandom);
      v.flush = ($urandom_range(0, 7) == 0);
      v.flush_mid = $urandom_range(0, 1) == 1;
      v.nms = $urandom_range(0, 3);
      v.nw = $urandom_range(0, 3);
      acc = (v.rd || v.wr) && !v.addr[0] && !v.flush;
      isw = v.wr;
      v.exp_stall = acc ? 2 + v.nms + v.nw : 0;
      v.exp_rd = (acc && !isw) ? 1 + v.nms : 0;
      v.exp_wr = (acc && isw) ? 1 + v.nms : 0;
      v.exp_align = ((v.rd || v.wr) && !v.flush && v.addr[0]) ? 1 : 0;
      if (acc && !isw) model_rdata = v.rdata;
      v.exp_rdata = model_rdata;
      do_access(v, o);
      check_access($sformatf("rnd%0d", i), v, o);
    end

    @(negedge clk); idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
